// File: rtl/dmem_arb_defs.sv
// Shared definitions for the data-memory arbiter: owner-state encoding and owner ids.
package dmem_arb_defs;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CPU      = 2'd1,
    S_DBG      = 2'd2,
    S_DBG_LOCK = 2'd3
  } arb_state_e;

  // Owner ids double as bit positions in the two-way request/grant vectors.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; a forced requester wins when it is also requesting.
module rr_pick2
  import dmem_arb_defs::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] force_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (force_i[OWN_DBG] && req_i[OWN_DBG]) begin
      gnt_o = 2'b10;
    end else if (force_i[OWN_CPU] && req_i[OWN_CPU]) begin
      gnt_o = 2'b01;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // Tie goes to whoever did not own the last granted beat.
        2'b11:   gnt_o = (last_i == OWN_DBG) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and a debug/loader port,
// round-robin with a bounded debug lock; read data is registered back to the winner.
module dmem_arbiter
  import dmem_arb_defs::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [1:0]               cpu_size,
  input  logic                     cpu_sign_ext,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_stall,
  output logic                     cpu_rvalid,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,

  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [1:0]               dbg_size,
  input  logic                     dbg_sign_ext,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0]    dbg_wdata,
  input  logic                     dbg_lock,
  output logic                     dbg_gnt,
  output logic                     dbg_rvalid,
  output logic [DATA_WIDTH-1:0]    dbg_rdata,

  output logic                     mem_we,
  output logic [1:0]               mem_size,
  output logic                     mem_sign_ext,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstMax  = CntW'(MAX_BURST);
  // Staying locked needs burst_cnt + 1 < MAX_BURST, i.e. burst_cnt < MAX_BURST - 1.
  localparam logic [CntW-1:0] LockLimit = CntW'(MAX_BURST - 1);

  arb_state_e          state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;

  logic                lock_hold;
  logic                cpu_force;
  logic [1:0]          pick;
  logic                cpu_grant;
  logic                dbg_grant;
  logic                cpu_rd;
  logic                dbg_rd;

  logic                cpu_rvalid_q;
  logic                dbg_rvalid_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;

  // Dropping dbg_lock or dbg_req releases the lock in the same cycle.
  assign lock_hold = (state_q == S_DBG_LOCK) && dbg_req && dbg_lock &&
                     (burst_cnt_q < BurstMax);
  assign cpu_force = (burst_cnt_q >= BurstMax) && cpu_req;

  rr_pick2 u_pick (
    .req_i   ({dbg_req, cpu_req}),
    .last_i  (last_owner_q),
    .force_i ({lock_hold, cpu_force}),
    .gnt_o   (pick)
  );

  // Reset gates every grant combinationally so a write cannot commit while rst is low.
  assign cpu_grant = pick[OWN_CPU] & rst;
  assign dbg_grant = pick[OWN_DBG] & rst;
  assign cpu_rd    = cpu_grant & ~cpu_we;
  assign dbg_rd    = dbg_grant & ~dbg_we;

  assign cpu_stall = cpu_req & ~cpu_grant & rst;
  assign dbg_gnt   = dbg_grant;

  always_comb begin
    mem_we       = 1'b0;
    mem_size     = 2'b00;
    mem_sign_ext = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    if (cpu_grant) begin
      mem_we       = cpu_we;
      mem_size     = cpu_size;
      mem_sign_ext = cpu_sign_ext;
      mem_addr     = cpu_addr;
      mem_din      = cpu_wdata;
    end else if (dbg_grant) begin
      mem_we       = dbg_we;
      mem_size     = dbg_size;
      mem_sign_ext = dbg_sign_ext;
      mem_addr     = dbg_addr;
      mem_din      = dbg_wdata;
    end
  end

  always_comb begin
    state_d      = S_IDLE;
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    if (dbg_grant) begin
      last_owner_d = OWN_DBG;
      if (dbg_lock && (burst_cnt_q < LockLimit)) begin
        state_d     = S_DBG_LOCK;
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        state_d = S_DBG;
      end
    end else if (cpu_grant) begin
      state_d      = S_CPU;
      last_owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWN_DBG;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rd;
      dbg_rvalid_q <= dbg_rd;
      if (cpu_rd) begin
        cpu_rdata_q <= mem_dout;
      end
      if (dbg_rd) begin
        dbg_rdata_q <= mem_dout;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus a reset-during-write sequence.
module tb_dmem_arbiter;

  localparam logic [4:0] OpNone = 5'b0_0_0_00;  // {req, we, sign_ext, size}
  localparam logic [4:0] RdW    = 5'b1_0_0_10;
  localparam logic [4:0] WrW    = 5'b1_1_0_10;
  localparam logic [4:0] WrB    = 5'b1_1_0_00;
  localparam logic [4:0] RdB    = 5'b1_0_0_00;
  localparam logic [4:0] RdBs   = 5'b1_0_1_00;

  typedef struct {
    logic [4:0]  cop;
    logic [3:0]  ca;
    logic [31:0] cd;
    logic [4:0]  dop;
    logic        dl;
    logic [3:0]  da;
    logic [31:0] dd;
    logic        e_stall;
    logic        e_gnt;
    logic        e_we;
    logic [3:0]  e_addr;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign_ext = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [3:0]  cpu_addr = 4'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_sign_ext = 1'b0, dbg_lock = 1'b0;
  logic [1:0]  dbg_size = 2'b00;
  logic [3:0]  dbg_addr = 4'h0;
  logic [31:0] dbg_wdata = 32'h0;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_we, mem_sign_ext;
  logic [1:0]  mem_size;
  logic [3:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (4),
    .MAX_BURST     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_sign_ext (cpu_sign_ext),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_size     (dbg_size),
    .dbg_sign_ext (dbg_sign_ext),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_lock     (dbg_lock),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_sign_ext (mem_sign_ext),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Little-endian byte memory: combinational read, write at the clock edge.
  logic [7:0] mem [16] = '{default: 8'h00};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din[7:0];
      if (mem_size != 2'd0) mem[mem_addr + 4'd1] <= mem_din[15:8];
      if (mem_size == 2'd2) begin
        mem[mem_addr + 4'd2] <= mem_din[23:16];
        mem[mem_addr + 4'd3] <= mem_din[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[mem_addr];
    b1 = mem[mem_addr + 4'd1];
    b2 = mem[mem_addr + 4'd2];
    b3 = mem[mem_addr + 4'd3];
    case (mem_size)
      2'd0:    mem_dout = mem_sign_ext ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'd1:    mem_dout = mem_sign_ext ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: mem_dout = {b3, b2, b1, b0};
    endcase
  end

  function automatic vec_t mk(input logic [4:0] cop, input logic [3:0] ca,
                              input logic [31:0] cd, input logic [4:0] dop, input int dl,
                              input logic [3:0] da, input logic [31:0] dd, input int st,
                              input int gn, input int we, input logic [3:0] ea, input int crv,
                              input logic [31:0] crd, input int drv, input logic [31:0] drd);
    vec_t v;
    v.cop = cop; v.ca = ca; v.cd = cd;
    v.dop = dop; v.dl = 1'(dl); v.da = da; v.dd = dd;
    v.e_stall = 1'(st); v.e_gnt = 1'(gn); v.e_we = 1'(we); v.e_addr = ea;
    v.e_crv = 1'(crv); v.e_crd = crd; v.e_drv = 1'(drv); v.e_drd = drd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    {cpu_req, cpu_we, cpu_sign_ext, cpu_size} = v.cop;
    cpu_addr = v.ca;
    cpu_wdata = v.cd;
    {dbg_req, dbg_we, dbg_sign_ext, dbg_size} = v.dop;
    dbg_lock = v.dl;
    dbg_addr = v.da;
    dbg_wdata = v.dd;
    #1;
    check({tag, " cpu_stall"}, 32'(cpu_stall), 32'(v.e_stall));
    check({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'(v.e_gnt));
    check({tag, " mem_we"}, 32'(mem_we), 32'(v.e_we));
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
    check({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(v.e_crv));
    check({tag, " cpu_rdata"}, cpu_rdata, v.e_crd);
    check({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(v.e_drv));
    check({tag, " dbg_rdata"}, dbg_rdata, v.e_drd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cpu_stall"}, 32'(cpu_stall), 32'h0);
    check({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'h0);
    check({tag, " mem_we"}, 32'(mem_we), 32'h0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, " mem_din"}, mem_din, 32'h0);
    check({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
    check({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
    check({tag, " cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, " dbg_rdata"}, dbg_rdata, 32'h0);
  endtask

  initial begin
    // cop, ca, cd, dop, lock, da, dd | stall, gnt, we, addr, crv, crd, drv, drd
    // Tie: CPU wins first, then alternation.
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 0, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 0, 4'h1, 0, 1, 1, 0, 4'h1, 1, 0, 0, 0));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 0, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 0, 4'h1, 0, 1, 1, 0, 4'h1, 1, 0, 0, 0));
    // CPU store then load of 0xDEADBEEF at address 4.
    vecs.push_back(mk(WrW, 4'h4, 32'hDEADBEEF, OpNone, 0, 4'h0, 0,
                      0, 0, 1, 4'h4, 0, 0, 1, 0));
    vecs.push_back(mk(RdW, 4'h4, 0, OpNone, 0, 4'h0, 0, 0, 0, 0, 4'h4, 0, 0, 0, 0));
    vecs.push_back(mk(OpNone, 4'h0, 0, OpNone, 0, 4'h0, 0,
                      0, 0, 0, 4'h0, 1, 32'hDEADBEEF, 0, 0));
    // Debug preload: byte 0x80 at 12, word 0x11223344 at 8; byte loads with/without sign ext.
    vecs.push_back(mk(OpNone, 4'h0, 0, WrB, 0, 4'hC, 32'h80,
                      0, 1, 1, 4'hC, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(OpNone, 4'h0, 0, WrW, 0, 4'h8, 32'h11223344,
                      0, 1, 1, 4'h8, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(OpNone, 4'h0, 0, RdB, 0, 4'hC, 0,
                      0, 1, 0, 4'hC, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(OpNone, 4'h0, 0, RdBs, 0, 4'hC, 0,
                      0, 1, 0, 4'hC, 0, 32'hDEADBEEF, 1, 32'h80));
    vecs.push_back(mk(OpNone, 4'h0, 0, OpNone, 0, 4'h0, 0,
                      0, 0, 0, 4'h0, 0, 32'hDEADBEEF, 1, 32'hFFFFFF80));
    // Locked burst with CPU contending: CPU, 4 debug beats, CPU, debug resumes.
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0,
                      0, 0, 0, 4'h0, 0, 32'hDEADBEEF, 0, 32'hFFFFFF80));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 1, 0, 0, 32'hFFFFFF80));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 1, 0, 0, 32'h11223344));
    // Early release after beat 2: CPU takes beat 3, then a full 4-beat burst again.
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 0, 4'h8, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 1, 0, 0, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 1, 1, 0, 4'h8, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(RdW, 4'h0, 0, RdW, 1, 4'h8, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h11223344));
    vecs.push_back(mk(OpNone, 4'h0, 0, OpNone, 0, 4'h0, 0,
                      0, 0, 0, 4'h0, 1, 0, 0, 32'h11223344));

    // Reset state, with both requesters asserted while rst is low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    dbg_we = 1'b1;
    #1;
    check_reset_outputs("init");
    @(negedge clk);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    rst = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset pulsed in the middle of a granted debug write to address 8.
    @(negedge clk);
    {cpu_req, cpu_we, cpu_sign_ext, cpu_size} = RdW;
    cpu_addr = 4'h0;
    {dbg_req, dbg_we, dbg_sign_ext, dbg_size} = WrW;
    dbg_lock = 1'b0;
    dbg_addr = 4'h8;
    dbg_wdata = 32'h12345678;
    #1;
    check("pre_rst dbg_gnt", 32'(dbg_gnt), 32'h1);
    check("pre_rst mem_we", 32'(mem_we), 32'h1);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    {cpu_req, cpu_we, cpu_sign_ext, cpu_size} = OpNone;
    {dbg_req, dbg_we, dbg_sign_ext, dbg_size} = OpNone;
    rst = 1'b1;
    apply(mk(OpNone, 4'h0, 0, RdW, 0, 4'h8, 0, 0, 1, 0, 4'h8, 0, 0, 0, 0), "post_rst rd");
    apply(mk(OpNone, 4'h0, 0, OpNone, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h11223344),
          "post_rst data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port little-endian data memory (`memTopo32LittleEndian`) between the CPU's memory stage and a debug/loader port. It multiplexes address, size, sign-extend, write-data and write-enable onto the memory. It registers read data back to the winning requester and stalls the CPU when it loses arbitration. Fairness is round-robin, with a bounded lock so the debug port can issue short atomic bursts.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDRESS_WIDTH, 4, byte-address width into data memory
- MAX_BURST, 4, max consecutive locked debug beats (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_size  in  2  funct3[1:0] access size
- cpu_sign_ext  in  1  funct3[2] load sign control
- cpu_addr  in  ADDRESS_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_stall  out  1  CPU request present but not granted
- cpu_rvalid  out  1  cpu_rdata holds new load data
- cpu_rdata  out  DATA_WIDTH  registered load data
- dbg_req, dbg_we, dbg_size[1:0], dbg_sign_ext, dbg_addr, dbg_wdata  in  (as CPU)  debug request fields
- dbg_lock  in  1  keep grant for next beat
- dbg_gnt  out  1  debug request granted this cycle
- dbg_rvalid  out  1  dbg_rdata holds new load data
- dbg_rdata  out  DATA_WIDTH  registered load data
- mem_we, mem_size[1:0], mem_sign_ext, mem_addr, mem_din  out  to data memory
- mem_dout  in  DATA_WIDTH  combinational memory read data

## Operation
- Owner states: S_IDLE, S_CPU, S_DBG, S_DBG_LOCK. State is registered and holds the owner of the previous beat.
- Grant is decided each cycle:
  - S_DBG_LOCK with dbg_req=1 and burst_cnt<MAX_BURST: debug wins unconditionally.
  - Otherwise, if only one requester is active, it wins.
  - If both are active, the requester not granted last wins. `last_owner` resets to DBG, so the CPU wins the first tie.
  - If burst_cnt has reached MAX_BURST and cpu_req=1, the CPU must win the next beat.
- The granted requester's fields drive mem_*. With no grant: mem_we=0 and all other mem_* outputs are 0.
- cpu_stall = cpu_req & ~cpu_grant. dbg_gnt = dbg_grant.
- Next state:
  - Debug granted with dbg_lock=1 and burst_cnt+1<MAX_BURST → S_DBG_LOCK.
  - Debug granted otherwise → S_DBG.
  - CPU granted → S_CPU.
  - No grant → S_IDLE. `last_owner` is unchanged.
- burst_cnt increments on each debug grant while the state is or enters S_DBG_LOCK. It clears on any non-locked state.
- Lock release: dbg_lock or dbg_req dropping in S_DBG_LOCK releases the lock immediately, and the same cycle uses normal round-robin.
- MAX_BURST=1 makes lock ineffective.
- Reads: on a granted read, mem_dout is captured into that requester's rdata at the edge, and its rvalid=1 for exactly the next cycle. rdata holds until the next read.
- Writes: a granted write commits at the rising edge ending the grant cycle. No rvalid is produced.

## Timing
- Grant, stall and mem_* outputs are combinational from requests and registered state, in the same cycle.
- Write commit: 1 edge. Read data latency: 1 cycle (rvalid at cycle N+1 for a grant at N).
- Reset (rst=0, any time):
  - state=S_IDLE, last_owner=DBG, burst_cnt=0.
  - rvalid=0 for both ports; cpu_rdata=0 and dbg_rdata=0.
  - While rst=0, all grants, mem_we, cpu_stall and dbg_gnt are forced to 0.
  - A write in the cycle reset asserts must not commit.
- Simultaneous new request and release: the release takes effect first, then arbitration is evaluated, in the same cycle.

## Structure
- Shared package/header `dmem_arb_defs`: state encoding (2-bit S_IDLE=0, S_CPU=1, S_DBG=2, S_DBG_LOCK=3), owner constants OWN_CPU=0, OWN_DBG=1.
- Sub-module `rr_pick2`: combinational two-way round-robin picker (req[1:0], last, force) → grant[1:0].
- Top level contains the state register, burst counter, the request-field mux and the rdata/rvalid registers.

## Test plan
- Reset then cpu_req=1, dbg_req=1 together → cycle 0 grants CPU (cpu_stall=0, dbg_gnt=0); cycle 1 grants debug (cpu_stall=1); grants alternate while both remain asserted.
- CPU store of 0xDEADBEEF to addr 4 (size=2), then CPU load from addr 4 → mem_we=1 only on the store beat; cpu_rvalid=1 one cycle after the load grant with cpu_rdata=0xDEADBEEF; dbg_rvalid stays 0.
- MAX_BURST=4, dbg_lock=1, dbg_req=1 and cpu_req=1 held → debug granted 4 consecutive beats, then the CPU is granted 1 beat, then debug resumes.
- dbg_lock deasserted after beat 2 of a locked burst with cpu_req=1 → CPU granted on beat 3; burst_cnt returns to 0.
- Debug byte load (size=0, sign_ext=0) from an address holding 0x80 → dbg_rdata=0x00000080; with sign_ext=1 → dbg_rdata=0xFFFFFF80.
- rst pulsed low during a granted debug write (addr 8, data 0x12345678) → mem_we=0 while rst is low; a later read of addr 8 returns its prior value; all outputs are at their reset values.
